// File: rtl/mmio_port_if.sv
// mmio_port_if: the CPU memory-bus control signals as seen by a responder
// that sits beside the RAM.
//   CS, WE  chip select / write enable from the CPU
//   ADDR    7-bit word address
//   sel     window-hit output from the responder; the top level uses it to
//           mask the RAM chip select
// The 32-bit data bus is kept as a plain inout net on the responder so that
// tristate resolution happens on an ordinary wire rather than across an
// interface boundary.
interface mmio_port_if;
    logic       CS;
    logic       WE;
    logic [6:0] ADDR;
    logic       sel;

    modport master (output CS, output WE, output ADDR, input sel);
    modport slave  (input CS, input WE, input ADDR, output sel);
endinterface

// File: rtl/mmio_port.sv
// mmio_port: memory-mapped I/O responder sharing the RAM bus. Claims a
// 4-word window at BASE_ADDR and offers an output latch, a synchronized
// switch input and a prescaled countdown timer with a sticky expiry flag.
// All state moves on the falling edge of CLK, like the RAM.
//   CLK        system clock
//   RST        asynchronous, active-high reset
//   bus        CS/WE/ADDR in, sel out (sel is a pure address decode)
//   Mem_Bus    shared 32-bit data bus, driven only during a hit read
//   SW_In      asynchronous switch inputs
//   D_Out      OUT register
//   Timer_IRQ  sticky expiry flag (level)
// Register map (ADDR[1:0]): 0 OUT, 1 IN, 2 COUNT/RELOAD, 3 CTRL/STATUS
// (bit0 EN, bit1 AUTO, bit2 EXP with write-1-to-clear).
module mmio_port #(
    parameter logic [6:0] BASE_ADDR = 7'h7C,
    parameter int         PRESCALE  = 1,
    parameter int         IN_WIDTH  = 16
) (
    input  logic                CLK,
    input  logic                RST,
    mmio_port_if.slave          bus,
    inout  wire  [31:0]         Mem_Bus,
    input  logic [IN_WIDTH-1:0] SW_In,
    output logic [31:0]         D_Out,
    output logic                Timer_IRQ
);
    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic [31:0]         out_q, out_d;
    logic [IN_WIDTH-1:0] sync_q, in_q;
    logic [31:0]         count_q, count_d;
    logic [31:0]         reload_q, reload_d;
    logic [15:0]         pre_q, pre_d;
    logic                en_q, en_d;
    logic                auto_q, auto_d;
    logic                exp_q, exp_d;
    logic [31:0]         rdata_q, rdata_d;

    logic        wr_hit, rd_hit, run, tick, exp_set, exp_clr;
    logic [31:0] in_ext;

    assign bus.sel   = (bus.ADDR[6:2] == BASE_ADDR[6:2]);
    assign Mem_Bus   = (bus.CS & ~bus.WE & bus.sel) ? rdata_q : 32'bz;
    assign D_Out     = out_q;
    assign Timer_IRQ = exp_q;

    always_comb begin
        wr_hit   = bus.CS & bus.WE & bus.sel;
        rd_hit   = bus.CS & ~bus.WE & bus.sel;
        in_ext   = '0;
        in_ext[IN_WIDTH-1:0] = in_q;

        // The prescaler only runs while there is something to count down.
        run      = en_q && (count_q != 32'd0);
        tick     = run && (pre_q == PRE_MAX);
        pre_d    = run ? (tick ? 16'd0 : pre_q + 16'd1) : 16'd0;

        count_d  = count_q;
        reload_d = reload_q;
        out_d    = out_q;
        en_d     = en_q;
        auto_d   = auto_q;
        exp_set  = 1'b0;
        exp_clr  = 1'b0;

        if (tick) begin
            if (count_q == 32'd1) begin
                exp_set = 1'b1;
                count_d = auto_q ? reload_q : 32'd0;
            end else begin
                count_d = count_q - 32'd1;
            end
        end

        // Bus writes come after the timer update so a COUNT load wins.
        if (wr_hit) begin
            case (bus.ADDR[1:0])
                2'd0: out_d = Mem_Bus;
                2'd2: begin
                    count_d  = Mem_Bus;
                    reload_d = Mem_Bus;
                    pre_d    = 16'd0;
                end
                2'd3: begin
                    en_d    = Mem_Bus[0];
                    auto_d  = Mem_Bus[1];
                    exp_clr = Mem_Bus[2];
                end
                default: ;
            endcase
        end

        // Expiry on the same edge beats the write-1 clear.
        exp_d = exp_set ? 1'b1 : (exp_clr ? 1'b0 : exp_q);

        rdata_d = rdata_q;
        if (rd_hit) begin
            case (bus.ADDR[1:0])
                2'd0:    rdata_d = out_q;
                2'd1:    rdata_d = in_ext;
                2'd2:    rdata_d = count_q;
                default: rdata_d = {29'd0, exp_q, auto_q, en_q};
            endcase
        end
    end

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            out_q    <= '0;
            sync_q   <= '0;
            in_q     <= '0;
            count_q  <= '0;
            reload_q <= '0;
            pre_q    <= '0;
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            exp_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            out_q    <= out_d;
            sync_q   <= SW_In;
            in_q     <= sync_q;
            count_q  <= count_d;
            reload_q <= reload_d;
            pre_q    <= pre_d;
            en_q     <= en_d;
            auto_q   <= auto_d;
            exp_q    <= exp_d;
            rdata_q  <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mmio_port.sv
module tb_mmio_port;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cs = 1'b0, we = 1'b0, wdrv = 1'b0;
    logic [6:0]  addr = 7'd0;
    logic [31:0] wdata = 32'd0;
    logic [15:0] sw = 16'd0;
    wire  [31:0] bus_a, bus_b;
    logic [31:0] dout_a, dout_b;
    logic        irq_a, irq_b;

    mmio_port_if ifa();
    mmio_port_if ifb();

    assign ifa.CS = cs;   assign ifa.WE = we;   assign ifa.ADDR = addr;
    assign ifb.CS = cs;   assign ifb.WE = we;   assign ifb.ADDR = addr;
    assign bus_a = wdrv ? wdata : 32'bz;
    assign bus_b = wdrv ? wdata : 32'bz;

    mmio_port #(.BASE_ADDR(7'h7C), .PRESCALE(1), .IN_WIDTH(16)) dut_a (
        .CLK(CLK), .RST(RST), .bus(ifa.slave), .Mem_Bus(bus_a),
        .SW_In(sw), .D_Out(dout_a), .Timer_IRQ(irq_a));

    mmio_port #(.BASE_ADDR(7'h7C), .PRESCALE(4), .IN_WIDTH(16)) dut_b (
        .CLK(CLK), .RST(RST), .bus(ifb.slave), .Mem_Bus(bus_b),
        .SW_In(sw), .D_Out(dout_b), .Timer_IRQ(irq_b));

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        bit          on_b;
    } rd_exp_t;
    rd_exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_float(input string tag, input logic [31:0] obs);
        checks++;
        assert ($isunknown(obs) || obs === 32'd0) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=undriven", tag, obs);
        end
    endtask

    task automatic drive(input bit c, input bit w, input logic [6:0] a, input logic [31:0] d);
        @(posedge CLK);
        #1;
        cs = c; we = w; addr = a; wdata = d; wdrv = c & w;
    endtask

    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, a, d);
        settle();
    endtask

    task automatic idle(input logic [6:0] a);
        drive(1'b0, 1'b0, a, 32'd0);
        settle();
    endtask

    task automatic rd(input bit on_b, input logic [6:0] a, input logic [31:0] exp, input string tag);
        rd_exp_t e;
        drive(1'b1, 1'b0, a, 32'd0);
        sb.push_back('{tag, exp, on_b});
        settle();
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk(e.tag, e.on_b ? bus_b : bus_a, e.exp);
        end
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2;
        cs = 1'b0; we = 1'b0; wdrv = 1'b0;
        RST = 1'b1;
        #1;
        RST = 1'b0;
    endtask

    initial begin
        #12 RST = 1'b0;

        // Reset state and register read-back
        chk("rst_dout", dout_a, 32'd0);
        chk("rst_irq", {31'd0, irq_a}, 32'd0);
        chk_float("rst_bus_idle", bus_a);
        rd(0, 7'h7C, 32'd0, "rst_out");
        rd(0, 7'h7D, 32'd0, "rst_in");
        rd(0, 7'h7E, 32'd0, "rst_count");
        rd(0, 7'h7F, 32'd0, "rst_ctrl");

        // OUT latch, IN read-only, decode
        wr(7'h7C, 32'hDEADBEEF);
        chk("dout_after_sw", dout_a, 32'hDEADBEEF);
        wr(7'h7D, 32'h12345678);
        rd(0, 7'h7D, 32'd0, "in_write_ignored");
        rd(0, 7'h7C, 32'hDEADBEEF, "out_readback");
        idle(7'h7E);
        chk("sel_without_cs", {31'd0, ifa.sel}, 32'd1);
        chk_float("bus_float_cs0", bus_a);
        drive(1'b1, 1'b0, 7'h10, 32'd0);
        settle();
        chk("sel_miss", {31'd0, ifa.sel}, 32'd0);
        chk_float("bus_float_miss", bus_a);

        // One-shot countdown, PRESCALE=1
        do_reset();
        wr(7'h7E, 32'd3);
        wr(7'h7F, 32'd1);
        rd(0, 7'h7E, 32'd3, "p1_count_e1");
        chk("p1_irq_e1", {31'd0, irq_a}, 32'd0);
        rd(0, 7'h7E, 32'd2, "p1_count_e2");
        chk("p1_irq_e2", {31'd0, irq_a}, 32'd0);
        rd(0, 7'h7E, 32'd1, "p1_count_e3");
        chk("p1_irq_e3", {31'd0, irq_a}, 32'd1);
        rd(0, 7'h7E, 32'd0, "p1_count_idle");
        rd(0, 7'h7F, 32'd5, "p1_status");

        // Write-1-clear on the expiry edge loses to the set
        do_reset();
        wr(7'h7E, 32'd2);
        wr(7'h7F, 32'd1);
        idle(7'h00);
        wr(7'h7F, 32'd5);
        chk("clr_vs_expire", {31'd0, irq_a}, 32'd1);
        wr(7'h7F, 32'd5);
        chk("clr_after", {31'd0, irq_a}, 32'd0);
        rd(0, 7'h7F, 32'd1, "clr_status");

        // COUNT write beats a decrement
        do_reset();
        wr(7'h7E, 32'd5);
        wr(7'h7F, 32'd1);
        idle(7'h00);
        wr(7'h7E, 32'd9);
        rd(0, 7'h7E, 32'd9, "load_vs_dec");
        rd(0, 7'h7E, 32'd8, "load_then_dec");

        // Auto-reload, PRESCALE=4
        do_reset();
        wr(7'h7E, 32'd2);
        wr(7'h7F, 32'd3);
        for (int k = 1; k <= 16; k++) begin
            if (k == 9)       rd(1, 7'h7E, 32'd2, "p4_reload");
            else if (k == 10) wr(7'h7F, 32'd7);
            else              idle(7'h00);
            chk($sformatf("p4_irq_e%0d", k), {31'd0, irq_b},
                {31'd0, ((k >= 8 && k < 10) || k >= 16)});
        end

        // Async reset mid-count, then switch synchronizer latency
        do_reset();
        wr(7'h7C, 32'h0000A5A5);
        wr(7'h7E, 32'd5);
        wr(7'h7F, 32'd1);
        idle(7'h00);
        idle(7'h00);
        chk("pre_rst_dout", dout_a, 32'h0000A5A5);
        @(posedge CLK);
        #2;
        cs = 1'b0; we = 1'b0; wdrv = 1'b0;
        RST = 1'b1;
        #1;
        chk("midrst_dout", dout_a, 32'd0);
        chk("midrst_irq", {31'd0, irq_a}, 32'd0);
        RST = 1'b0;
        rd(0, 7'h7E, 32'd0, "midrst_count");
        rd(0, 7'h7F, 32'd0, "midrst_ctrl");
        for (int k = 0; k < 5; k++) idle(7'h00);
        rd(0, 7'h7E, 32'd0, "midrst_no_tick");

        sw = 16'h00A5;
        rd(0, 7'h7D, 32'd0, "sw_edge1");
        rd(0, 7'h7D, 32'd0, "sw_edge2");
        rd(0, 7'h7D, 32'h000000A5, "sw_edge3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
